// File: rtl/sector_access_scheduler.sv
// Sector access scheduler: waits for a target sector, delays, then opens a
// timed read/write window; reports done/overrun/timeout/abort pulses.
// Ports: clock, reset (async, active-low), clkenbl_1usec/_sector/_index,
//   Sector_Address, req_valid/req_ready/req_sector/req_write, abort,
//   busy, window_active, window_write, done, overrun, timeout, aborted.
// Optional (SCHED_ERRCNT_EN): err_clear in, err_count[7:0] out.
module sector_access_scheduler #(
  parameter int SECTOR_BITS = 2,
  parameter int DELAY_US    = 250,
  parameter int WINDOW_US   = 4500,
  parameter int MAX_INDEX   = 2
) (
  input  logic                   clock,
  input  logic                   reset,
`ifdef SCHED_ERRCNT_EN
  input  logic                   err_clear,
  output logic [7:0]             err_count,
`endif
  input  logic                   clkenbl_1usec,
  input  logic                   clkenbl_sector,
  input  logic                   clkenbl_index,
  input  logic [SECTOR_BITS-1:0] Sector_Address,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [SECTOR_BITS-1:0] req_sector,
  input  logic                   req_write,
  input  logic                   abort,
  output logic                   busy,
  output logic                   window_active,
  output logic                   window_write,
  output logic                   done,
  output logic                   overrun,
  output logic                   timeout,
  output logic                   aborted
);

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DELAY,
    ACTIVE
  } state_t;

  state_t state_q, state_d;

  logic [SECTOR_BITS-1:0] tgt_q;
  logic                   wr_q;
  logic [3:0]             idx_q;
  logic [3:0]             idx_nxt;
  logic [15:0]            us_q;
  logic                   pend_q;
  logic                   wa_q;
  logic                   ww_q;

  logic match;
  logic dly_hit;
  logic win_hit;
  logic latch;
  logic idx_clr;
  logic idx_inc;
  logic us_inc;

  // pend_q delays the sector pulse one cycle so the address has advanced
  assign match   = pend_q && (Sector_Address == tgt_q);
  assign idx_nxt = (idx_q == 4'hf) ? idx_q : idx_q + 4'd1;
  assign dly_hit = (us_q == 16'(DELAY_US - 1));
  assign win_hit = (us_q == 16'(WINDOW_US - 1));

  assign busy          = (state_q != IDLE);
  assign req_ready     = (state_q == IDLE);
  assign window_active = wa_q;
  assign window_write  = ww_q;

  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    idx_clr = 1'b0;
    idx_inc = 1'b0;
    us_inc  = 1'b0;
    done    = 1'b0;
    overrun = 1'b0;
    timeout = 1'b0;
    aborted = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          latch   = 1'b1;
          idx_clr = 1'b1;
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        if (abort) begin
          aborted = 1'b1;
          state_d = IDLE;
        end else if (match) begin
          state_d = DELAY;
        end else if (clkenbl_index) begin
          idx_inc = 1'b1;
          if (idx_nxt == 4'(MAX_INDEX)) begin
            timeout = 1'b1;
            state_d = IDLE;
          end
        end
      end
      DELAY: begin
        if (abort) begin
          aborted = 1'b1;
          state_d = IDLE;
        end else if (clkenbl_sector) begin
          done    = 1'b1;
          overrun = 1'b1;
          state_d = IDLE;
        end else if (clkenbl_1usec) begin
          if (dly_hit) state_d = ACTIVE;
          else         us_inc  = 1'b1;
        end
      end
      ACTIVE: begin
        if (abort) begin
          aborted = 1'b1;
          state_d = IDLE;
        end else if (clkenbl_sector) begin
          done    = 1'b1;
          overrun = 1'b1;
          state_d = IDLE;
        end else if (clkenbl_1usec) begin
          if (win_hit) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            us_inc = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      us_q    <= '0;
      pend_q  <= 1'b0;
      wa_q    <= 1'b0;
      ww_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= (state_q == SEARCH) && clkenbl_sector;
      if (latch) begin
        tgt_q <= req_sector;
        wr_q  <= req_write;
      end
      if (idx_clr)      idx_q <= '0;
      else if (idx_inc) idx_q <= idx_nxt;
      // every state change restarts the usec count
      if (state_d != state_q) us_q <= '0;
      else if (us_inc)        us_q <= us_q + 16'd1;
      wa_q <= (state_d == ACTIVE);
      ww_q <= (state_d == ACTIVE) && wr_q;
    end
  end

`ifdef SCHED_ERRCNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_count <= '0;
    end else if (err_clear) begin
      err_count <= '0;
    end else if ((timeout || overrun) && (err_count != 8'hff)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sector_access_scheduler.sv
// Bench for sector_access_scheduler: directed and random access timelines
// checked cycle by cycle against an event-level reference model.
module tb_sector_access_scheduler;

  localparam int DLY  = 3;
  localparam int WIN  = 8;
  localparam int MAXI = 2;
  localparam int L    = 440;
  localparam int NR   = 40;

  localparam int K_NONE = 0;
  localparam int K_DONE = 1;
  localparam int K_OVR  = 2;
  localparam int K_TO   = 3;
  localparam int K_AB   = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       clkenbl_1usec = 1'b0;
  logic       clkenbl_sector = 1'b0;
  logic       clkenbl_index = 1'b0;
  logic [1:0] Sector_Address = 2'd0;
  logic       req_valid = 1'b0;
  logic [1:0] req_sector = 2'd0;
  logic       req_write = 1'b0;
  logic       abort = 1'b0;
  logic       req_ready, busy, window_active, window_write;
  logic       done, overrun, timeout, aborted;
`ifdef SCHED_ERRCNT_EN
  logic       err_clear = 1'b0;
  logic [7:0] err_count;
`endif

  always #5 clock = ~clock;

  sector_access_scheduler #(
    .SECTOR_BITS(2),
    .DELAY_US(DLY),
    .WINDOW_US(WIN),
    .MAX_INDEX(MAXI)
  ) dut (
    .clock(clock),
    .reset(reset),
`ifdef SCHED_ERRCNT_EN
    .err_clear(err_clear),
    .err_count(err_count),
`endif
    .clkenbl_1usec(clkenbl_1usec),
    .clkenbl_sector(clkenbl_sector),
    .clkenbl_index(clkenbl_index),
    .Sector_Address(Sector_Address),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_sector(req_sector),
    .req_write(req_write),
    .abort(abort),
    .busy(busy),
    .window_active(window_active),
    .window_write(window_write),
    .done(done),
    .overrun(overrun),
    .timeout(timeout),
    .aborted(aborted)
  );

  int errors = 0;
  int checks = 0;

  bit         sec[L];
  bit         idx[L];
  bit         us[L];
  bit         ab[L];
  bit         rv[L];
  logic [1:0] addr[L];
  logic [7:0] expv[L];
  logic [1:0] tgt;
  logic       wr;
  int         kind;
  int         e_end;
  int         w_open;
  int         err_model = 0;

  function automatic logic [7:0] observe();
    return {busy, req_ready, window_active, window_active & window_write,
            done, overrun, timeout, aborted};
  endfunction

  // mode 0 normal read, 1 timeout, 2 overrun write, 3 random
  task automatic gen(input int mode);
    int p, ph, ip, iph, uph;
    bit son, ion;
    logic [1:0] a;
    son = 1'b1;
    ion = 1'b1;
    uph = $urandom_range(0, 3);
    ph  = $urandom_range(2, 20);
    ip  = $urandom_range(50, 120);
    iph = $urandom_range(1, ip - 1);
    p   = $urandom_range(16, 60);
    a   = 2'($urandom_range(0, 3));
    tgt = 2'($urandom_range(0, 3));
    wr  = 1'($urandom_range(0, 1));
    case (mode)
      0: begin tgt = 2'd2; wr = 1'b0; p = 60; a = 2'd0; ion = 1'b0; end
      1: begin tgt = 2'd3; son = 1'b0; ip = 50; iph = 10; end
      2: begin tgt = 2'd1; wr = 1'b1; p = 30; a = 2'd0; ion = 1'b0; end
      default: if ($urandom_range(0, 4) == 0) son = 1'b0;
    endcase
    for (int t = 0; t < L; t++) begin
      sec[t] = son && ((t % p) == ph);
      idx[t] = ion && ((t % ip) == iph);
      us[t]  = ((t % 4) == uph);
      ab[t]  = 1'b0;
      rv[t]  = (t == 0);
    end
    addr[0] = a;
    for (int t = 1; t < L; t++)
      addr[t] = sec[t-1] ? addr[t-1] + 2'd1 : addr[t-1];
    if (mode == 3 && $urandom_range(0, 3) == 0)
      ab[$urandom_range(1, 150)] = 1'b1;
  endtask

  // Event-level model: find match / timeout / abort, then count usec
  // enables for the delay and window, any sector pulse cutting them short.
  task automatic run_model();
    int t, m, cnt, n, phase;
    bit b, wa, fin;
    kind   = K_NONE;
    e_end  = -1;
    w_open = -1;
    m      = -1;
    cnt    = 0;
    t      = 1;
    while (t < L && e_end < 0 && m < 0) begin
      if (idx[t] && cnt < 15) cnt++;
      if (ab[t]) begin
        kind = K_AB; e_end = t;
      end else if (t >= 2 && sec[t-1] && addr[t] == tgt) begin
        m = t;
      end else if (idx[t] && cnt == MAXI) begin
        kind = K_TO; e_end = t;
      end
      t++;
    end
    if (m >= 0) begin
      n = 0;
      phase = 0;
      t = m + 1;
      while (t < L && e_end < 0) begin
        if (ab[t]) begin
          kind = K_AB; e_end = t;
        end else if (sec[t]) begin
          kind = K_OVR; e_end = t;
        end else if (us[t]) begin
          n++;
          if (phase == 0 && n == DLY) begin
            w_open = t; phase = 1; n = 0;
          end else if (phase == 1 && n == WIN) begin
            kind = K_DONE; e_end = t;
          end
        end
        t++;
      end
    end
    for (int k = 0; k < L; k++) begin
      b   = (e_end >= 0) && k >= 1 && k <= e_end;
      wa  = (w_open >= 0) && k > w_open && k <= e_end;
      fin = (k == e_end);
      expv[k] = {b, !b, wa, wa & wr,
                 fin && (kind == K_DONE || kind == K_OVR),
                 fin && kind == K_OVR, fin && kind == K_TO,
                 fin && kind == K_AB};
    end
  endtask

  task automatic drive(input int scen, input int rst_at);
    logic [7:0] obs;
    checks++;
    assert (e_end >= 0) else begin
      errors++;
      $error("FAIL bound scen=%0d observed end=%0d required end>=0",
             scen, e_end);
    end
    for (int t = 0; t < L; t++) begin
      @(posedge clock);
      #1;
      req_valid      = rv[t];
      req_sector     = tgt;
      req_write      = wr;
      clkenbl_sector = sec[t];
      clkenbl_index  = idx[t];
      clkenbl_1usec  = us[t];
      abort          = ab[t];
      Sector_Address = addr[t];
      @(negedge clock);
      obs = observe();
      checks++;
      assert (obs === expv[t]) else begin
        errors++;
        $error("FAIL cycle scen=%0d t=%0d observed=%b required=%b",
               scen, t, obs, expv[t]);
      end
      if (t == rst_at) begin
        #1 reset = 1'b0;
        #1 obs = observe();
        checks++;
        assert (obs === 8'b0100_0000) else begin
          errors++;
          $error("FAIL async_reset observed=%b required=%b",
                 obs, 8'b0100_0000);
        end
`ifdef SCHED_ERRCNT_EN
        checks++;
        assert (err_count === 8'd0) else begin
          errors++;
          $error("FAIL reset_errcnt observed=%0d required=0", err_count);
        end
`endif
        break;
      end
    end
    req_valid      = 1'b0;
    clkenbl_sector = 1'b0;
    clkenbl_index  = 1'b0;
    clkenbl_1usec  = 1'b0;
    abort          = 1'b0;
    if (rst_at >= 0) begin
      @(posedge clock);
      #2 reset = 1'b1;
      err_model = 0;
    end else if (kind == K_OVR || kind == K_TO) begin
      if (err_model < 255) err_model++;
    end
  endtask

  initial begin
    logic [7:0] obs;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 obs = observe();
    checks++;
    assert (obs === 8'b0100_0000) else begin
      errors++;
      $error("FAIL reset_state observed=%b required=%b",
             obs, 8'b0100_0000);
    end
    #2 reset = 1'b1;

    for (int i = 0; i < NR; i++) begin
      gen(i < 3 ? i : (i < 5 ? 0 : 3));
      run_model();
      if (i == 3 && w_open >= 0) begin
        ab[w_open + 5] = 1'b1;
        run_model();
      end
      if (i == 4 && e_end >= 0 && e_end < L - 3) begin
        for (int t = 0; t <= e_end + 1; t++) rv[t] = 1'b1;
        ab[e_end + 2]   = 1'b1;
        expv[e_end + 2] = 8'b1000_0001;
      end
      drive(i, -1);
    end

`ifdef SCHED_ERRCNT_EN
    checks++;
    assert (err_count === 8'(err_model)) else begin
      errors++;
      $error("FAIL errcnt_random observed=%0d required=%0d",
             err_count, err_model);
    end
`endif

    gen(0);
    run_model();
    drive(NR, w_open + 6);

    for (int i = 0; i < 3; i++) begin
      gen(1);
      run_model();
      drive(NR + 1 + i, -1);
    end

`ifdef SCHED_ERRCNT_EN
    checks++;
    assert (err_count === 8'(err_model)) else begin
      errors++;
      $error("FAIL errcnt_three observed=%0d required=%0d",
             err_count, err_model);
    end
    @(posedge clock);
    #1 err_clear = 1'b1;
    @(posedge clock);
    #1 err_clear = 1'b0;
    checks++;
    assert (err_count === 8'd0) else begin
      errors++;
      $error("FAIL errcnt_clear observed=%0d required=0", err_count);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sector_access_scheduler.md
Name: sector_access_scheduler

Overview:
Sequences a single disk sector access on top of the sector/index pulse generator. A requester asks for a target sector and an operation (read or write). The block waits until that sector comes under the heads, then waits a fixed post-pulse delay and opens a timed data window for the read/write datapath. It also reports completion, overrun, abort and a "sector never found" timeout. It sits between the drive-command logic and the sector_and_index / read/write data paths.

Parameters:
SECTOR_BITS, 2, width of the sector address and the target.
DELAY_US, 250, microseconds from the matching sector pulse to window open; legal range 1..4095.
WINDOW_US, 4500, data window length in microseconds; legal range 1..65535.
MAX_INDEX, 2, index pulses seen while searching before a timeout; legal range 1..15.

Ports:
clock  in  1  master clock, 40 MHz
reset  in  1  reset, asynchronous, active-low
clkenbl_1usec  in  1  one-cycle 1 usec enable
clkenbl_sector  in  1  one-cycle enable at each sector pulse
clkenbl_index  in  1  one-cycle enable at each index pulse
Sector_Address  in  SECTOR_BITS  current sector under the heads
req_valid  in  1  access request
req_ready  out  1  request accepted when req_valid and req_ready are both high
req_sector  in  SECTOR_BITS  target sector
req_write  in  1  1 = write, 0 = read
abort  in  1  cancel the access in progress
busy  out  1  high in any state other than IDLE
window_active  out  1  data window open
window_write  out  1  latched req_write; valid while window_active
done  out  1  one-cycle pulse on normal or overrun completion
overrun  out  1  one-cycle pulse, coincident with done, when the window was cut short
timeout  out  1  one-cycle pulse when the target sector was not found
aborted  out  1  one-cycle pulse when an access is cancelled

Behaviour:
- Reset (reset low, asynchronous): state = IDLE; all counters cleared. Outputs: req_ready = 1; every other output = 0.
- States: IDLE, SEARCH, DELAY, ACTIVE.
- IDLE:
  - req_ready = 1.
  - On req_valid: latch req_sector and req_write, clear index_cnt, go to SEARCH on the next clock.
  - req_ready = 0 in every other state.
- SEARCH:
  - A clkenbl_sector pulse sets an internal pend flag.
  - On the cycle after pend is set, compare Sector_Address with the target. This gives the address counter one cycle to update.
  - On a match: clear the usec counter, go to DELAY.
  - On clkenbl_index: increment index_cnt. When index_cnt reaches MAX_INDEX: pulse timeout, go to IDLE.
  - If a match and the terminal index count occur in the same cycle, the match wins.
- DELAY:
  - Count clkenbl_1usec pulses.
  - On the DELAY_US-th pulse: go to ACTIVE and clear the counter.
- ACTIVE:
  - window_active = 1 and window_write = latched op, both registered. window_active rises the cycle after the DELAY_US-th usec enable.
  - On the WINDOW_US-th usec enable: pulse done, go to IDLE. window_active falls on the same edge.
- Overrun: a clkenbl_sector pulse in DELAY or ACTIVE ends the access immediately. Pulse done and overrun together, go to IDLE.
- Abort: abort high in SEARCH, DELAY or ACTIVE pulses aborted and goes to IDLE the next cycle; no done.
  - abort wins over a done, overrun or timeout in the same cycle.
  - abort in IDLE is ignored.
- Pulse and counter widths:
  - All status pulses are exactly one clock wide.
  - The usec counter is 16 bits and never wraps, because it is cleared on every state entry.
  - index_cnt is 4 bits and saturates.
- Timing edge case: if clkenbl_1usec and clkenbl_sector occur in the same cycle during DELAY or ACTIVE, the overrun rule applies.
- Mid-operation reset returns to IDLE immediately, with no status pulse.

Optional Feature:
- Macro: SCHED_ERRCNT_EN.
- When defined:
  - Adds output err_count[7:0]: a saturating count of timeout and overrun events. Abort does not count.
  - Adds input err_clear: a synchronous clear that has priority over an increment.
  - Reset value of err_count is 0.
- When undefined: neither port exists, and behaviour is otherwise identical.

Test Plan:
1. Normal read, default parameters: request sector 2, read; sector pulses every 5000 us with the address advancing 0,1,2,3. Required: window_active rises 250 us after the sector-2 pulse and lasts 4500 us; window_write = 0; one done; no overrun.
2. Timeout, MAX_INDEX = 2: request sector 3 with sector pulses suppressed, index pulses every 40000 us. Required: timeout pulses on the 2nd index pulse; busy falls the next cycle; done stays 0.
3. Overrun, WINDOW_US = 6000: write to sector 1. Required: the next sector pulse, 5000 us after the match, ends the window 4750 us after it opened; done and overrun pulse in the same cycle; window_write = 1 during the window.
4. Abort: assert abort 100 us into ACTIVE. Required: aborted pulse; window_active low the next cycle; no done.
5. Handshake: hold req_valid high for the entire access. Required: req_ready = 0 while busy; the second request is accepted only once back in IDLE.
6. Reset: drop reset mid-ACTIVE. Required: asynchronous clear of all outputs; req_ready = 1. With SCHED_ERRCNT_EN defined, run test 2 three times: err_count = 3; then pulse err_clear: err_count = 0.
